// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: conditions the pause/clear buttons and the
// adjust/select switches, divides the system clock into 1 Hz / 2 Hz ticks
// and issues single-cycle strobes to the minutes/seconds counter datapath.
//
// Ports
//   timer        in   system clock (rising edge)
//   reset        in   synchronous active-high reset
//   btn_pause    in   raw pause/run button
//   btn_clear    in   raw clear button
//   sw_adj       in   raw adjust-mode switch
//   sw_sel       in   raw select switch (1 = minutes, 0 = seconds)
//   cnt_tick     out  one-cycle strobe: advance seconds (RUN only)
//   cnt_clear    out  one-cycle strobe: zero minutes and seconds
//   adj_min_inc  out  one-cycle strobe: increment minutes (ADJUST)
//   adj_sec_inc  out  one-cycle strobe: increment seconds (ADJUST)
//   blink        out  display blink phase
//   running      out  high in RUN
//   mode         out  state: 00 PAUSED, 01 RUN, 10 ADJUST
module stopwatch_ctrl #(
  parameter int unsigned SEC_DIV         = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned PS_W            = 27,
  parameter int unsigned DB_W            = 20
) (
  input  logic       timer,
  input  logic       reset,
  input  logic       btn_pause,
  input  logic       btn_clear,
  input  logic       sw_adj,
  input  logic       sw_sel,
  output logic       cnt_tick,
  output logic       cnt_clear,
  output logic       adj_min_inc,
  output logic       adj_sec_inc,
  output logic       blink,
  output logic       running,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    ST_PAUSED = 2'b00,
    ST_RUN    = 2'b01,
    ST_ADJUST = 2'b10
  } state_t;

  localparam int unsigned N_IN = 4;  // pause, clear, adj, sel
  localparam int unsigned N_BTN = 2; // pause, clear are debounced
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(SEC_DIV - 1);
  localparam logic [PS_W-1:0] PS_HALF = PS_W'(SEC_DIV / 2 - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Input conditioning state
  logic [N_IN-1:0]  w_raw;
  logic [N_IN-1:0]  r_sync1;
  logic [N_IN-1:0]  r_sync2;
  logic [1:0]       r_vld;
  logic [DB_W-1:0]  r_db_cnt [N_BTN];
  logic [N_BTN-1:0] r_db_lvl;
  logic [N_BTN-1:0] r_db_prev;
  logic [N_BTN-1:0] r_armed;
  logic [N_BTN-1:0] w_rise;
  logic             w_pause_rise;
  logic             w_clear_rise;
  logic             w_adj;
  logic             w_sel;

  // Control state
  state_t           r_state;
  state_t           w_state_n;
  logic [PS_W-1:0]  r_ps;
  logic [PS_W-1:0]  w_ps_n;
  logic             w_t1;
  logic             w_t2;
  logic             r_cnt_tick, w_tick_n;
  logic             r_cnt_clear, w_clear_n;
  logic             r_adj_min, w_min_n;
  logic             r_adj_sec, w_sec_n;
  logic             r_blink, w_blink_n;
  logic             r_running;

  assign w_raw = {sw_sel, sw_adj, btn_clear, btn_pause};

  // Synchronizers, button debouncers and post-reset arming
  always_ff @(posedge timer) begin
    if (reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_vld     <= '0;
      r_db_lvl  <= '0;
      r_db_prev <= '0;
      r_armed   <= '0;
      for (int i = 0; i < int'(N_BTN); i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1   <= w_raw;
      r_sync2   <= r_sync1;
      r_vld     <= {r_vld[0], 1'b1};
      r_db_prev <= r_db_lvl;
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (r_sync2[i] == r_db_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db_lvl[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
        // A button only arms once a genuine released sample is seen after
        // reset, so a button held through reset cannot produce an edge.
        if (r_vld[1] && !r_sync2[i] && !r_db_lvl[i]) r_armed[i] <= 1'b1;
      end
    end
  end

  assign w_rise       = r_db_lvl & ~r_db_prev & r_armed;
  assign w_pause_rise = w_rise[0];
  assign w_clear_rise = w_rise[1];
  assign w_adj        = r_sync2[2];
  assign w_sel        = r_sync2[3];

  assign w_t1 = (r_ps == PS_LAST);
  assign w_t2 = w_t1 || (r_ps == PS_HALF);

  // State register, prescaler and registered outputs
  always_ff @(posedge timer) begin
    if (reset) begin
      r_state     <= ST_PAUSED;
      r_ps        <= '0;
      r_cnt_tick  <= 1'b0;
      r_cnt_clear <= 1'b0;
      r_adj_min   <= 1'b0;
      r_adj_sec   <= 1'b0;
      r_blink     <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_ps        <= w_ps_n;
      r_cnt_tick  <= w_tick_n;
      r_cnt_clear <= w_clear_n;
      r_adj_min   <= w_min_n;
      r_adj_sec   <= w_sec_n;
      r_blink     <= w_blink_n;
      r_running   <= (w_state_n == ST_RUN);
    end
  end

  // Next state and next output values
  always_comb begin
    w_state_n = r_state;
    w_ps_n    = r_ps + PS_W'(1);
    w_tick_n  = 1'b0;
    w_clear_n = w_clear_rise;
    w_min_n   = 1'b0;
    w_sec_n   = 1'b0;
    w_blink_n = 1'b0;

    // Adjust switch dominates; pause edges are dropped while it is high
    if (w_adj) begin
      w_state_n = ST_ADJUST;
    end else begin
      case (r_state)
        ST_ADJUST: w_state_n = ST_PAUSED;
        ST_PAUSED: if (w_pause_rise) w_state_n = ST_RUN;
        ST_RUN:    if (w_pause_rise) w_state_n = ST_PAUSED;
        default:   w_state_n = ST_PAUSED;
      endcase
    end

    // Restart the second on RUN entry so the first tick is a full period away
    if ((w_state_n == ST_RUN) && (r_state != ST_RUN)) begin
      w_ps_n = '0;
    end else if (w_t1) begin
      w_ps_n = '0;
    end

    // Clear suppresses every other strobe in its cycle
    if (!w_clear_rise) begin
      w_tick_n = w_t1 && (r_state == ST_RUN) && (w_state_n == ST_RUN);
      w_min_n  = w_t2 && (r_state == ST_ADJUST) && w_sel;
      w_sec_n  = w_t2 && (r_state == ST_ADJUST) && !w_sel;
    end

    // Blink drops together with leaving ADJUST
    if (w_state_n == ST_ADJUST) begin
      w_blink_n = r_blink ^ (w_t2 && (r_state == ST_ADJUST));
    end
  end

  assign cnt_tick    = r_cnt_tick;
  assign cnt_clear   = r_cnt_clear;
  assign adj_min_inc = r_adj_min;
  assign adj_sec_inc = r_adj_sec;
  assign blink       = r_blink;
  assign running     = r_running;
  assign mode        = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: a cycle-level behavioural model checked on
// every negedge, plus directed scenarios with hand-derived literal checks.
module tb_stopwatch_ctrl;

  localparam int SEC_DIV = 10;
  localparam int DBC     = 4;
  localparam int HMAX    = 4096;

  logic       timer = 1'b0;
  logic       reset = 1'b1;
  logic       btn_pause = 1'b0;
  logic       btn_clear = 1'b0;
  logic       sw_adj = 1'b0;
  logic       sw_sel = 1'b0;
  logic       cnt_tick, cnt_clear, adj_min_inc, adj_sec_inc, blink, running;
  logic [1:0] mode;

  int checks = 0;
  int failures = 0;

  stopwatch_ctrl #(
    .SEC_DIV(SEC_DIV), .DEBOUNCE_CYCLES(DBC), .PS_W(4), .DB_W(3)
  ) dut (
    .timer(timer), .reset(reset), .btn_pause(btn_pause), .btn_clear(btn_clear),
    .sw_adj(sw_adj), .sw_sel(sw_sel), .cnt_tick(cnt_tick), .cnt_clear(cnt_clear),
    .adj_min_inc(adj_min_inc), .adj_sec_inc(adj_sec_inc), .blink(blink),
    .running(running), .mode(mode)
  );

  always #5 timer = ~timer;

  // ---------------- behavioural model ----------------
  // Raw input history per channel (0 pause, 1 clear, 2 adj, 3 sel), indexed
  // by clock edge counted from reset release.
  bit h_raw [4][HMAX];
  bit m_live = 1'b0;
  int m_e;          // edges since reset release
  int m_origin;     // edge at which the current second started
  int m_st;         // 0 PAUSED, 1 RUN, 2 ADJUST
  bit m_db   [2];
  bit m_dbp  [2];
  bit m_arm  [2];
  bit m_tick, m_clr, m_amin, m_asec, m_blink;

  // Synchronised value seen at edge e is the raw value two edges earlier.
  function automatic bit sync_at(input int ch, input int e);
    if (e < 2) return 1'b0;
    return h_raw[ch][e-2];
  endfunction

  // Level changes after DBC consecutive synchronised samples disagree with it.
  function automatic bit db_flip(input int ch, input bit lvl, input int e);
    for (int k = 0; k < DBC; k++)
      if (sync_at(ch, e - k) == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge timer) begin
    if (reset) begin
      m_live = 1'b1; m_e = 0; m_origin = 0; m_st = 0;
      for (int i = 0; i < 2; i++) begin m_db[i] = 0; m_dbp[i] = 0; m_arm[i] = 0; end
      m_tick = 0; m_clr = 0; m_amin = 0; m_asec = 0; m_blink = 0;
    end else if (m_live && m_e < HMAX) begin
      bit prise, crise, adj, sel, t1, t2, s;
      int ph, stn;
      h_raw[0][m_e] = btn_pause;
      h_raw[1][m_e] = btn_clear;
      h_raw[2][m_e] = sw_adj;
      h_raw[3][m_e] = sw_sel;
      prise = m_db[0] && !m_dbp[0] && m_arm[0];
      crise = m_db[1] && !m_dbp[1] && m_arm[1];
      adj = sync_at(2, m_e);
      sel = sync_at(3, m_e);
      ph = (m_e - m_origin) % SEC_DIV;
      t1 = (ph == SEC_DIV - 1);
      t2 = t1 || (ph == SEC_DIV / 2 - 1);
      if (adj) stn = 2;
      else if (m_st == 2) stn = 0;
      else if (prise) stn = (m_st == 0) ? 1 : 0;
      else stn = m_st;
      if (stn == 1 && m_st != 1) m_origin = m_e + 1;
      m_clr  = crise;
      m_tick = t1 && m_st == 1 && stn == 1 && !crise;
      m_amin = t2 && m_st == 2 && sel && !crise;
      m_asec = t2 && m_st == 2 && !sel && !crise;
      m_blink = (stn == 2) ? (m_blink ^ (t2 && m_st == 2)) : 1'b0;
      for (int i = 0; i < 2; i++) begin
        s = sync_at(i, m_e);
        if (m_e >= 2 && !s && !m_db[i]) m_arm[i] = 1'b1;
        m_dbp[i] = m_db[i];
        if (db_flip(i, m_db[i], m_e)) m_db[i] = !m_db[i];
      end
      m_st = stn;
      m_e++;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge timer) begin
    if (m_live) begin
      logic [7:0] exp_v, got_v;
      exp_v = {m_tick, m_clr, m_amin, m_asec, m_blink, (m_st == 1), 2'(m_st)};
      got_v = {cnt_tick, cnt_clear, adj_min_inc, adj_sec_inc, blink, running, mode};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL model_cmp t=%0t got(tick,clr,min,sec,blink,run,mode)=%b expected=%b",
                 $time, got_v, exp_v);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int w_t, w_c, w_am, w_as, w_bt, w_mc;
  int a_t, a_c, a_mc;
  int first_k, found, gap;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge timer);
  endtask

  // Count output events over n cycles, sampling on the falling edge
  task automatic watch(input int n, output int ticks, output int clrs, output int amins,
                       output int asecs, output int btog, output int mchg);
    logic pb;
    logic [1:0] pm;
    ticks = 0; clrs = 0; amins = 0; asecs = 0; btog = 0; mchg = 0;
    pb = blink; pm = mode;
    repeat (n) begin
      @(negedge timer);
      if (cnt_tick) ticks++;
      if (cnt_clear) clrs++;
      if (adj_min_inc) amins++;
      if (adj_sec_inc) asecs++;
      if (blink !== pb) btog++;
      if (mode !== pm) mchg++;
      pb = blink; pm = mode;
    end
  endtask

  initial begin
    step(3);
    reset = 1'b0;

    // 1: idle after reset
    watch(50, w_t, w_c, w_am, w_as, w_bt, w_mc);
    chk("idle_strobes", w_t + w_c + w_am + w_as, 0);
    chk("idle_mode", int'(mode), 0);
    chk("idle_running", int'(running), 0);

    // 2: press pause -> RUN after 7 cycles, ticks every 10
    btn_pause = 1'b1; first_k = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge timer);
      if (running && first_k == 0) first_k = k;
    end
    btn_pause = 1'b0;
    chk("run_entry_latency", first_k, 7);
    watch(52, w_t, w_c, w_am, w_as, w_bt, w_mc);
    chk("run_ticks_in_52", w_t, 5);
    chk("run_mode", int'(mode), 1);
    // second press leaves RUN exactly on a t1 cycle: no tick at all
    btn_pause = 1'b1;
    watch(8, a_t, w_c, w_am, w_as, w_bt, a_mc);
    btn_pause = 1'b0;
    watch(30, w_t, w_c, w_am, w_as, w_bt, w_mc);
    chk("pause_ticks", a_t + w_t, 0);
    chk("pause_mode", int'(mode), 0);

    // 3: bounce shorter than debounce, then a stable press
    btn_pause = 1'b1; step(1); btn_pause = 1'b0; step(1);
    btn_pause = 1'b1; step(1); btn_pause = 1'b0;
    watch(12, w_t, w_c, w_am, w_as, w_bt, w_mc);
    chk("bounce_mode_changes", w_mc, 0);
    btn_pause = 1'b1;
    watch(6, w_t, w_c, w_am, w_as, w_bt, a_mc);
    btn_pause = 1'b0;
    watch(14, w_t, w_c, w_am, w_as, w_bt, w_mc);
    chk("stable_press_changes", a_mc + w_mc, 1);
    chk("stable_press_mode", int'(mode), 1);

    // 4: clear held for 10 cycles in RUN -> one pulse, state kept
    btn_clear = 1'b1;
    watch(10, w_t, a_c, w_am, w_as, w_bt, a_mc);
    btn_clear = 1'b0;
    watch(15, w_t, w_c, w_am, w_as, w_bt, w_mc);
    chk("clear_pulses", a_c + w_c, 1);
    chk("clear_mode_changes", a_mc + w_mc, 0);
    chk("clear_mode", int'(mode), 1);
    // clear edge aligned with t1: clear wins
    found = 0;
    for (int k = 0; k < 15 && found == 0; k++) begin
      @(negedge timer);
      if (cnt_tick) found = 1;
    end
    chk("tick_found", found, 1);
    step(3);
    btn_clear = 1'b1;
    step(7);
    chk("clr_vs_tick_clear", int'(cnt_clear), 1);
    chk("clr_vs_tick_tick", int'(cnt_tick), 0);
    step(3);
    btn_clear = 1'b0;
    step(12);

    // 5: ADJUST, minutes then seconds
    sw_adj = 1'b1; sw_sel = 1'b1;
    step(4);
    chk("adj_mode", int'(mode), 2);
    found = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      @(negedge timer);
      if (adj_min_inc) found = 1;
    end
    chk("amin_found", found, 1);
    for (int g = 0; g < 3; g++) begin
      gap = 0; found = 0;
      for (int k = 1; k <= 12 && found == 0; k++) begin
        @(negedge timer);
        if (adj_min_inc) begin found = 1; gap = k; end
      end
      chk("amin_gap", gap, 5);
    end
    watch(30, w_t, w_c, w_am, w_as, w_bt, w_mc);
    chk("adj_min_count", w_am, 6);
    chk("adj_min_no_sec", w_as, 0);
    chk("adj_blink_toggles", w_bt, 6);
    sw_sel = 1'b0;
    step(3);
    watch(20, w_t, w_c, w_am, w_as, w_bt, w_mc);
    chk("adj_sec_count", w_as, 4);
    chk("adj_sec_no_min", w_am, 0);
    sw_adj = 1'b0;
    step(3);
    chk("adj_exit_mode", int'(mode), 0);
    chk("adj_exit_blink", int'(blink), 0);

    // 6: pause held through reset
    step(5);
    btn_pause = 1'b1;
    step(3);
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    watch(20, w_t, w_c, w_am, w_as, w_bt, w_mc);
    chk("held_reset_mode_changes", w_mc, 0);
    chk("held_reset_mode", int'(mode), 0);
    btn_pause = 1'b0;
    watch(10, w_t, w_c, w_am, w_as, w_bt, w_mc);
    chk("held_release_mode", int'(mode), 0);
    btn_pause = 1'b1;
    step(8);
    btn_pause = 1'b0;
    step(4);
    chk("repress_mode", int'(mode), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
